// File: rtl/complex_multiplier_pipe.sv
// Signed complex multiplier y = a*b or a*conj(b), with rounding right shift and narrowing to OUT_W.
// Latency: 4 cycles from the accept edge to out_valid; 1 sample/cycle throughput.
// Backpressure: a global stall (out_valid && !out_ready) freezes every stage; define CMULT_SAT_EN to saturate instead of wrap.
module complex_multiplier_pipe #(
  parameter int A_W   = 16,
  parameter int B_W   = 18,
  parameter int OUT_W = 35,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [A_W-1:0]   real_part_a,
  input  logic signed [A_W-1:0]   imag_part_a,
  input  logic signed [B_W-1:0]   real_part_b,
  input  logic signed [B_W-1:0]   imag_part_b,
  input  logic                    conj_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] real_output,
  output logic signed [OUT_W-1:0] imag_output,
  output logic                    out_last,
  output logic                    out_sat
);

  localparam int P_W    = A_W + B_W;
  localparam int FULL_W = A_W + B_W + 1;
  // One guard bit so the rounding constant can never overflow the sum.
  localparam int RW     = FULL_W + 1;
  localparam int WIDE   = (OUT_W > RW) ? OUT_W : RW;

  logic stall;
  logic v1, v2, v3, v4;

  logic signed [A_W-1:0]    s1_ar, s1_ai;
  logic signed [B_W-1:0]    s1_br, s1_bi;
  logic                     s1_conj, s1_last;
  logic signed [P_W-1:0]    s2_rr, s2_ii, s2_ri, s2_ir;
  logic                     s2_conj, s2_last;
  logic signed [FULL_W-1:0] s3_re, s3_im;
  logic                     s3_last;
  logic signed [RW-1:0]     s3_re_x, s3_im_x, re_sc, im_sc;
  logic signed [RW-1:0]     s4_re, s4_im;
  logic                     s4_last;
  logic signed [OUT_W-1:0]  re_nar, im_nar;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !rst && !stall;

  // Valid bits advance together; bubbles travel with the data and are not squeezed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
    end
  end

  // S1: capture operands and per-sample controls on the accept cycle only.
  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      s1_ar   <= real_part_a;
      s1_ai   <= imag_part_a;
      s1_br   <= real_part_b;
      s1_bi   <= imag_part_b;
      s1_conj <= conj_b;
      s1_last <= in_last;
    end
  end

  // S2: the four partial products at full product width.
  always_ff @(posedge clk) begin
    if (!stall && v1) begin
      s2_rr   <= P_W'(s1_ar) * P_W'(s1_br);
      s2_ii   <= P_W'(s1_ai) * P_W'(s1_bi);
      s2_ri   <= P_W'(s1_ar) * P_W'(s1_bi);
      s2_ir   <= P_W'(s1_ai) * P_W'(s1_br);
      s2_conj <= s2_conj_nxt_dummy(s1_conj);
      s2_last <= s1_last;
    end
  end

  function automatic logic s2_conj_nxt_dummy(input logic c);
    return c;
  endfunction

  // S3: combine products; conjugate mode flips the sign of the b-imag terms.
  always_ff @(posedge clk) begin
    if (!stall && v2) begin
      if (s2_conj) begin
        s3_re <= FULL_W'(s2_rr) + FULL_W'(s2_ii);
        s3_im <= FULL_W'(s2_ir) - FULL_W'(s2_ri);
      end else begin
        s3_re <= FULL_W'(s2_rr) - FULL_W'(s2_ii);
        s3_im <= FULL_W'(s2_ri) + FULL_W'(s2_ir);
      end
      s3_last <= s2_last;
    end
  end

  assign s3_re_x = RW'(s3_re);
  assign s3_im_x = RW'(s3_im);

  // Round half toward +inf: add half an output LSB, then arithmetic shift.
  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] RND = RW'(1) <<< (SHIFT - 1);
    assign re_sc = (s3_re_x + RND) >>> SHIFT;
    assign im_sc = (s3_im_x + RND) >>> SHIFT;
  end else begin : g_pass
    assign re_sc = s3_re_x;
    assign im_sc = s3_im_x;
  end

  // S4: hold the scaled full-precision result ahead of narrowing.
  always_ff @(posedge clk) begin
    if (!stall && v3) begin
      s4_re   <= re_sc;
      s4_im   <= im_sc;
      s4_last <= s3_last;
    end
  end

`ifdef CMULT_SAT_EN
  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [WIDE-1:0] re_w, im_w;
  logic re_hi, re_lo, im_hi, im_lo;

  assign re_w   = WIDE'(s4_re);
  assign im_w   = WIDE'(s4_im);
  assign re_hi  = re_w > SAT_MAX;
  assign re_lo  = re_w < SAT_MIN;
  assign im_hi  = im_w > SAT_MAX;
  assign im_lo  = im_w < SAT_MIN;
  assign re_nar = re_hi ? SAT_MAX[OUT_W-1:0] : (re_lo ? SAT_MIN[OUT_W-1:0] : re_w[OUT_W-1:0]);
  assign im_nar = im_hi ? SAT_MAX[OUT_W-1:0] : (im_lo ? SAT_MIN[OUT_W-1:0] : im_w[OUT_W-1:0]);

  // Clip flag travels with the output word it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sat <= 1'b0;
    end else if (!stall && v4) begin
      out_sat <= re_hi || re_lo || im_hi || im_lo;
    end
  end
`else
  // Size cast sign-extends when widening and keeps the low bits (wrap) when narrowing.
  assign re_nar  = OUT_W'(s4_re);
  assign im_nar  = OUT_W'(s4_im);
  assign out_sat = 1'b0;
`endif

  // Output register: loads only real samples, holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      real_output <= '0;
      imag_output <= '0;
      out_last    <= 1'b0;
    end else if (!stall && v4) begin
      real_output <= re_nar;
      imag_output <= im_nar;
      out_last    <= s4_last;
    end
  end

endmodule

// File: tb/tb_complex_multiplier_pipe.sv
// Bench for complex_multiplier_pipe: three instances (defaults, SHIFT=2, OUT_W=16) share one stimulus.
// Directed table vectors plus random streams checked against an arithmetic reference model.
// Honours CMULT_SAT_EN so expectations follow the build.
module tb_complex_multiplier_pipe;

`ifdef CMULT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk;
  logic rst, in_valid, out_ready, conj_b, in_last;
  logic signed [15:0] ar, ai;
  logic signed [17:0] br, bi;

  logic in_ready0, in_ready1, in_ready2;
  logic out_valid0, out_valid1, out_valid2;
  logic last0, last1, last2, sat0, sat1, sat2;
  logic signed [34:0] re0, im0, re1, im1;
  logic signed [15:0] re2, im2;

  complex_multiplier_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .conj_b(conj_b), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .real_output(re0), .imag_output(im0), .out_last(last0), .out_sat(sat0));

  complex_multiplier_pipe #(.SHIFT(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .conj_b(conj_b), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
    .real_output(re1), .imag_output(im1), .out_last(last1), .out_sat(sat1));

  complex_multiplier_pipe #(.OUT_W(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .real_part_a(ar), .imag_part_a(ai), .real_part_b(br), .imag_part_b(bi),
    .conj_b(conj_b), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
    .real_output(re2), .imag_output(im2), .out_last(last2), .out_sat(sat2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    bit     last;
    bit     sat;
  } exp_t;

  typedef struct {
    int     dut;
    longint ar, ai, br, bi;
    bit     cj;
    longint exp_re, exp_im;
    bit     exp_sat;
  } vec_t;

  exp_t   q0[$], q1[$], q2[$];
  int     xfer_t[$];
  int     total, bad, cyc, stall_cnt;
  bit     stalled_prev;
  longint hold_re, hold_im;
  bit     hold_last;
  vec_t   vt[12];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Round-half-up shift then wrap or clamp to ow bits, straight from the arithmetic definition.
  function automatic longint narrow(input longint v, input int sh, input int ow, output bit clipped);
    longint hi, lo, r;
    clipped = 1'b0;
    if (sh > 0) v = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -(longint'(1) <<< (ow - 1));
    if (SAT_EN) begin
      if (v > hi) begin r = hi; clipped = 1'b1; end
      else if (v < lo) begin r = lo; clipped = 1'b1; end
      else r = v;
    end else begin
      r = v & ((longint'(1) <<< ow) - 1);
      if (r > hi) r = r - (longint'(1) <<< ow);
    end
    return r;
  endfunction

  function automatic exp_t model(input longint a_r, input longint a_i, input longint b_r,
                                 input longint b_i, input bit cj, input bit lst,
                                 input int sh, input int ow);
    exp_t   e;
    longint re_f, im_f;
    bit     c1, c2;
    if (cj) begin
      re_f = a_r * b_r + a_i * b_i;
      im_f = a_i * b_r - a_r * b_i;
    end else begin
      re_f = a_r * b_r - a_i * b_i;
      im_f = a_r * b_i + a_i * b_r;
    end
    e.re   = narrow(re_f, sh, ow, c1);
    e.im   = narrow(im_f, sh, ow, c2);
    e.sat  = c1 || c2;
    e.last = lst;
    return e;
  endfunction

  function automatic vec_t mk(input int d, input longint a_r, input longint a_i, input longint b_r,
                              input longint b_i, input bit cj, input longint er, input longint ei,
                              input bit es);
    vec_t v;
    v.dut = d; v.ar = a_r; v.ai = a_i; v.br = b_r; v.bi = b_i; v.cj = cj;
    v.exp_re = er; v.exp_im = ei; v.exp_sat = es;
    return v;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input longint re, input longint im,
                         input bit lst, input bit sat);
    chk({tag, "_re"}, re, e.re);
    chk({tag, "_im"}, im, e.im);
    chk({tag, "_last"}, longint'(lst), longint'(e.last));
    chk({tag, "_sat"}, longint'(sat), longint'(e.sat));
  endtask

  task automatic pop_chk(input string tag, inout exp_t q[$], input longint re, input longint im,
                         input bit lst, input bit sat);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL %s_stale_output: out_valid=1 required 0 (nothing in flight)", tag);
    end else begin
      total--;
      e = q.pop_front();
      cmp_out(tag, e, re, im, lst, sat);
    end
  endtask

  // Scoreboard and stall observer, sampled on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q0.delete(); q1.delete(); q2.delete();
        stalled_prev = 1'b0;
      end else begin
        if (out_valid0 && !out_ready) begin
          stall_cnt++;
          chk("stall_in_ready", longint'(in_ready0 | in_ready1 | in_ready2), 0);
          if (stalled_prev) begin
            chk("hold_re", longint'(re0), hold_re);
            chk("hold_im", longint'(im0), hold_im);
            chk("hold_last", longint'(last0), longint'(hold_last));
          end
          stalled_prev = 1'b1;
          hold_re = longint'(re0); hold_im = longint'(im0); hold_last = last0;
        end else begin
          stalled_prev = 1'b0;
        end
        if (out_valid0 && out_ready) begin
          pop_chk("u0", q0, longint'(re0), longint'(im0), last0, sat0);
          xfer_t.push_back(cyc);
        end
        if (out_valid1 && out_ready) pop_chk("u1", q1, longint'(re1), longint'(im1), last1, sat1);
        if (out_valid2 && out_ready) pop_chk("u2", q2, longint'(re2), longint'(im2), last2, sat2);
        if (in_valid && in_ready0) begin
          q0.push_back(model(longint'(ar), longint'(ai), longint'(br), longint'(bi), conj_b, in_last, 0, 35));
          q1.push_back(model(longint'(ar), longint'(ai), longint'(br), longint'(bi), conj_b, in_last, 2, 35));
          q2.push_back(model(longint'(ar), longint'(ai), longint'(br), longint'(bi), conj_b, in_last, 0, 16));
        end
      end
    end
  endtask

  // One sample, measure edges from accept to out_valid, then compare the chosen instance.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(posedge clk); #1;
    ar = 16'(v.ar); ai = 16'(v.ai); br = 18'(v.br); bi = 18'(v.bi);
    conj_b = v.cj; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), longint'(lat), 4);
    case (v.dut)
      0: begin
        chk($sformatf("vec%0d_re", idx), longint'(re0), v.exp_re);
        chk($sformatf("vec%0d_im", idx), longint'(im0), v.exp_im);
      end
      1: begin
        chk($sformatf("vec%0d_re", idx), longint'(re1), v.exp_re);
        chk($sformatf("vec%0d_im", idx), longint'(im1), v.exp_im);
      end
      default: begin
        chk($sformatf("vec%0d_re", idx), longint'(re2), v.exp_re);
        chk($sformatf("vec%0d_im", idx), longint'(im2), v.exp_im);
        chk($sformatf("vec%0d_sat", idx), longint'(sat2), longint'(v.exp_sat));
      end
    endcase
  endtask

  // Random stream of n samples; out_ready drops for 5 cycles starting at cycle bp_at (if >= 0).
  task automatic stream(input int n, input int bp_at, input bit mark_last);
    int sent, i;
    bit need_new;
    logic [31:0] r;
    sent = 0; i = 0; need_new = 1'b1;
    while (sent < n && i < 500) begin
      @(posedge clk); #1;
      out_ready = !(bp_at >= 0 && i >= bp_at && i < bp_at + 5);
      if (need_new) begin
        r = $urandom; ar = r[15:0]; ai = r[31:16];
        r = $urandom; br = r[17:0]; conj_b = r[31];
        r = $urandom; bi = r[17:0];
        in_last = mark_last && (sent == n - 1);
        in_valid = 1'b1;
      end
      @(negedge clk);
      need_new = in_ready0;
      if (in_ready0) sent++;
      i++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", longint'(q0.size() + q1.size() + q2.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_cnt, sc0;
    total = 0; bad = 0; cyc = 0; stall_cnt = 0; stalled_prev = 1'b0;
    hold_re = 0; hold_im = 0; hold_last = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; conj_b = 1'b0; in_last = 1'b0;
    ar = '0; ai = '0; br = '0; bi = '0;

    vt[0]  = mk(0, 3, 4, 5, -2, 1'b0, 23, 14, 1'b0);
    vt[1]  = mk(0, 3, 4, 5, -2, 1'b1, 7, 26, 1'b0);
    vt[2]  = mk(1, 1, 0, 6, 0, 1'b0, 2, 0, 1'b0);
    vt[3]  = mk(1, 1, 0, 5, 0, 1'b0, 1, 0, 1'b0);
    vt[4]  = mk(1, 1, 0, -6, 0, 1'b0, -1, 0, 1'b0);
    vt[5]  = mk(1, 1, 0, 2, 0, 1'b0, 1, 0, 1'b0);
    vt[6]  = mk(1, 1, 0, -2, 0, 1'b0, 0, 0, 1'b0);
    vt[7]  = mk(2, 32767, 0, 131071, 0, 1'b0, SAT_EN ? 32767 : -32767, 0, SAT_EN);
    vt[8]  = mk(2, -32768, 0, 131071, 0, 1'b0, -32768, 0, SAT_EN);
    vt[9]  = mk(2, 100, 0, 200, 0, 1'b0, 20000, 0, 1'b0);
    vt[10] = mk(0, -32768, -32768, -131072, -131072, 1'b0, 0, 64'sd8589934592, 1'b0);
    vt[11] = mk(0, -32768, -32768, -131072, -131072, 1'b1, 64'sd8589934592, 0, 1'b0);

    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready0), 0);
    chk("rst_out_valid", longint'(out_valid0), 0);
    chk("rst_real", longint'(re0), 0);
    chk("rst_imag", longint'(im0), 0);
    chk("rst_last", longint'(last0), 0);
    chk("rst_sat", longint'(sat2), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", longint'(in_ready0), 1);

    // Directed table
    for (int i = 0; i < 12; i++) run_vec(i, vt[i]);
    drain();

    // Back-to-back stream of 10 with a frame marker on the last
    xfer_t.delete();
    stream(10, -1, 1'b1);
    drain();
    chk("b2b_count", longint'(xfer_t.size()), 10);
    if (xfer_t.size() == 10) chk("b2b_consecutive", longint'(xfer_t[9] - xfer_t[0]), 9);

    // Backpressure window mid-stream
    sc0 = stall_cnt;
    stream(20, 6, 1'b0);
    drain();
    chk("bp_stall_cycles", longint'(stall_cnt - sc0), 5);

    // Longer random stream with a later stall
    stream(40, 15, 1'b1);
    drain();

    // Reset with three samples in flight
    stream(3, -1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", longint'(in_ready0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", longint'(out_valid0), 0);
    ov_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid0 || out_valid1 || out_valid2) ov_cnt++;
    end
    chk("midrst_no_stale", longint'(ov_cnt), 0);
    run_vec(100, vt[1]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_multiplier_pipe.md
# complex_multiplier_pipe

Parametrised, fully pipelined signed complex multiplier with valid/ready flow control, a per-sample conjugate mode and a post-multiply scaling stage. It computes y = a·b or y = a·conj(b) for two's-complement operands of independent widths. It replaces the fixed-width free-running complex multiplier in the signal-processing datapath, sitting between sample sources (NCO, FIR outputs) and downstream accumulators or FFT stages that can apply backpressure.

## Interface
- `A_W`, 16: width of operand a real/imag parts (signed)
- `B_W`, 18: width of operand b real/imag parts (signed)
- `OUT_W`, 35: width of each output part (signed); full product width is `FULL_W = A_W+B_W+1`
- `SHIFT`, 0: arithmetic right shift applied to the full-precision result, with rounding; legal range 0..`FULL_W-1`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input sample valid
- `in_ready` out 1: block accepts a sample this cycle
- `real_part_a`, `imag_part_a` in `A_W`: operand a
- `real_part_b`, `imag_part_b` in `B_W`: operand b
- `conj_b` in 1: 1 selects a·conj(b) for this sample
- `in_last` in 1: frame marker, passed through aligned with its sample
- `out_valid` out 1: output sample valid
- `out_ready` in 1: downstream accepts output
- `real_output`, `imag_output` out `OUT_W`: result
- `out_last` out 1: aligned `in_last`
- `out_sat` out 1: the sample was clipped in either part (only meaningful with `CMULT_SAT_EN`)

## Operation
- Normal mode: `real = ar·br − ai·bi`; `imag = ar·bi + ai·br`.
- Conjugate mode: `real = ar·br + ai·bi`; `imag = ai·br − ar·bi`.
- All arithmetic is signed at `FULL_W`, so no intermediate overflow is possible.
- Pipeline stages:
  - S1: register inputs, `conj_b` and `in_last`.
  - S2: four partial products.
  - S3: add or subtract at `FULL_W`.
  - S4: scale and narrow to `OUT_W`.
- Scaling with `SHIFT>0`: add `2^(SHIFT−1)`, then arithmetic shift right by `SHIFT` (round half toward +inf). With `SHIFT=0`, pass through unchanged.
- Narrowing:
  - If `OUT_W ≥ FULL_W−SHIFT`: sign-extend.
  - Otherwise: saturate or wrap, per the Configuration section.
- Flow control:
  - A sample is accepted when `in_valid && in_ready`.
  - Output is transferred when `out_valid && out_ready`.
  - Global stall: `stall = out_valid && !out_ready`. While stalled, every stage holds its data and valid bit.
  - `in_ready = !rst && !stall`.
  - Bubbles (invalid stage slots) propagate; the pipeline does not compact them.
- Output data and `out_last`/`out_sat` stay stable while `out_valid && !out_ready`.

## Timing
- Latency is 4 cycles with no stall: a sample accepted at edge N appears with `out_valid=1` after edge N+4.
- Throughput: 1 sample per cycle when `out_ready` is held high.
- Reset:
  - All stage valid bits are 0.
  - `out_valid=0`, `real_output=0`, `imag_output=0`, `out_last=0`, `out_sat=0`.
  - `in_ready=0` while `rst=1`, and 1 in the first cycle after reset is released.
- Reset mid-operation: all in-flight samples are discarded and none are emitted after reset.
- `in_valid` while stalled: the sample is not accepted; the source must hold it.
- `out_ready` deasserted with `out_valid=0`: no stall occurs, and the pipeline keeps filling.
- `conj_b` and `in_last` are sampled only on the accept cycle.

## Configuration
- `CMULT_SAT_EN` defined:
  - Narrowing clamps each part to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - `out_sat=1` for any sample where either part clamped.
- `CMULT_SAT_EN` undefined:
  - Narrowing keeps the low `OUT_W` bits (two's-complement wrap).
  - `out_sat` is tied to 0.
  - The overflow-detect logic is not built.

## Test plan
- Defaults, `out_ready=1`:
  - a=3+4j, b=5−2j, `conj_b=0` → 23+14j after 4 cycles.
  - Same inputs with `conj_b=1` → 7+26j.
- Back-to-back stream: 10 random samples on consecutive cycles with a reference model → outputs in order on 10 consecutive cycles, all matching; `in_last` on sample 10 → `out_last` only on output 10.
- Backpressure: `out_ready=0` for 5 cycles mid-stream → `in_ready=0` while `out_valid=1`; output held stable; no sample lost or duplicated after `out_ready` returns.
- `SHIFT=2`, a=1+0j:
  - b=6 → real 2.
  - b=5 → real 1.
  - b=−6 → real −1.
- `OUT_W=16`, `SHIFT=0`, a=32767+0j, b=131071+0j:
  - With `CMULT_SAT_EN` → real 32767, `out_sat=1`.
  - Without it → real −32767 (0x8001), `out_sat=0`.
- Assert `rst` for 1 cycle with 3 samples in flight → `out_valid=0` next cycle; no stale outputs ever emitted; the next accepted sample has latency 4.
